// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC with wrap, one-entry output slot, redirect flush.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_BYTES = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        dbg_state
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [32:0] LAST_PC = 33'(MEM_BYTES - 4);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;

    logic        w_transfer;
    logic        w_slot_free;
    logic        w_fetch;
    logic [32:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    // Handshake: the slot hands over to decode on any edge where if_valid and
    // id_ready are both high; the slot may then be refilled on that same edge.
    assign w_transfer  = r_if_valid && id_ready;
    assign w_slot_free = !r_if_valid || w_transfer;
    assign w_fetch     = (r_state == RUN) && fetch_en && !redirect && w_slot_free;

    // 33-bit sum so an out-of-range redirect target near 2^32 cannot alias low.
    assign w_pc_plus4 = {1'b0, r_pc} + 33'd4;
    assign w_next_pc  = (w_pc_plus4 > LAST_PC) ? RESET_PC : w_pc_plus4[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'd0;
            r_if_pc    <= 32'd0;
        end else if (redirect) begin
            r_state    <= RUN;
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_if_valid <= 1'b0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (w_fetch) begin
                        r_if_inst  <= inst;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= w_next_pc;
                    end else if (!fetch_en && w_transfer) begin
                        r_if_valid <= 1'b0;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_fetch) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if ((r_state == RUN) && r_if_valid && !id_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

    assign pc        = r_pc;
    assign if_valid  = r_if_valid;
    assign if_inst   = r_if_inst;
    assign if_pc     = r_if_pc;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, sequential fetch with wrap, stall,
// redirect bubble, fetch_en gating and asynchronous reset mid-stall.
module tb_fetch_unit;

    localparam int MEM_BYTES = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_b [MEM_BYTES];

    fetch_unit #(.RESET_PC(32'd0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .inst        (inst),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Byte-addressed instruction store, big-endian word read
    always_comb begin
        inst = 32'hDEAD_BEEF;
        if (pc <= 32'(MEM_BYTES - 4)) begin
            inst = {mem_b[pc], mem_b[pc + 1], mem_b[pc + 2], mem_b[pc + 3]};
        end
    end

    function automatic logic [7:0] byte_at(input int a);
        return 8'((a * 17) ^ 8'hA5);
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        return {byte_at(a), byte_at(a + 1), byte_at(a + 2), byte_at(a + 3)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = byte_at(i);

        rst = 1'b1; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        step();
        step();
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_state", {31'd0, dbg_state}, 32'd0);

        rst = 1'b0;
        step();
        check_eq("boot_no_fetch", {31'd0, if_valid}, 32'd0);
        check_eq("boot_pc", pc, 32'd0);
        check_eq("boot_to_run", {31'd0, dbg_state}, 32'd1);

        // Free run through the wrap at 32 -> 0, ending with if_pc=8, pc=12
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq($sformatf("seq_valid_%0d", i), {31'd0, if_valid}, 32'd1);
            check_eq($sformatf("seq_pc_%0d", i), if_pc, 32'((4 * i) % MEM_BYTES));
            check_eq($sformatf("seq_inst_%0d", i), if_inst, exp_word((4 * i) % MEM_BYTES));
        end
        check_eq("pre_stall_pc", pc, 32'd12);

        // Stall three cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("stall_if_pc_%0d", i), if_pc, 32'd8);
            check_eq($sformatf("stall_pc_%0d", i), pc, 32'd12);
            check_eq($sformatf("stall_valid_%0d", i), {31'd0, if_valid}, 32'd1);
        end
`ifdef FETCH_PERF_CNT_EN
        check_eq("stall_count_3", stall_count, 32'd3);
        check_eq("fetch_count_12", fetch_count, 32'd12);
`endif
        id_ready = 1'b1;
        step();
        check_eq("unstall_if_pc", if_pc, 32'd12);
        check_eq("unstall_pc", pc, 32'd16);

        // Redirect to unaligned 0x17 -> 0x14, one bubble
        redirect = 1'b1; redirect_pc = 32'h17;
        step();
        redirect = 1'b0;
        check_eq("redir_pc", pc, 32'h14);
        check_eq("redir_flush", {31'd0, if_valid}, 32'd0);
        step();
        check_eq("redir_valid", {31'd0, if_valid}, 32'd1);
        check_eq("redir_if_pc", if_pc, 32'h14);
        check_eq("redir_if_inst", if_inst, exp_word(32'h14));
        check_eq("redir_next_pc", pc, 32'h18);

        // fetch_en low: transfer clears slot, pc and if_pc hold
        fetch_en = 1'b0;
        step();
        check_eq("fen0_valid", {31'd0, if_valid}, 32'd0);
        check_eq("fen0_pc", pc, 32'h18);
        check_eq("fen0_if_pc_hold", if_pc, 32'h14);
        step();
        check_eq("fen0_pc_hold2", pc, 32'h18);
        fetch_en = 1'b1;
        step();
        check_eq("fen1_if_pc", if_pc, 32'h18);
        check_eq("fen1_valid", {31'd0, if_valid}, 32'd1);

        // Redirect to last word, then wrap from there
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        step();
        check_eq("last_if_pc", if_pc, 32'h20);
        check_eq("last_wrap_pc", pc, 32'd0);

        // Asynchronous reset between edges during a stall
        id_ready = 1'b0;
        step();
        check_eq("pre_rst_stall", {31'd0, if_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_pc", pc, 32'd0);
        check_eq("arst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("arst_if_pc", if_pc, 32'd0);
        check_eq("arst_if_inst", if_inst, 32'd0);
        check_eq("arst_state", {31'd0, dbg_state}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("arst_fetch_count", fetch_count, 32'd0);
        check_eq("arst_stall_count", stall_count, 32'd0);
`endif
        #1;
        rst = 1'b0;
        id_ready = 1'b1;
        step();
        check_eq("reboot_no_fetch", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("reboot_if_pc_%0d", i), if_pc, 32'(4 * i));
        end
`ifdef FETCH_PERF_CNT_EN
        check_eq("reboot_fetch_count", fetch_count, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
